// File: rtl/mq_interval_update.sv
// mq_interval_update -- interval-update (IU) stage of the MQ arithmetic coder.
//
// Consumes the registered PE->IU outputs. For each symbol it updates the
// interval register A, decides whether Qe is added to C, computes the
// renormalisation shift, and writes the next probability state back to the
// context store. On a coder reset (rst_IU) it walks all 19 contexts through
// their initial states. Every output is registered, so latency is one cycle.
//
// Ports:
//   clk, rst                   clock, synchronous active-high global reset
//   valid_IU                   symbol present on the IU inputs
//   Qe_value_IU, NMPS_IU,
//   NLPS_IU, LZ0_IU            probability data of the current context
//   MPS_update_IU              MPS value to write back
//   MPS_coding_IU              1 = coded symbol is the MPS
//   CX_IU                      context number 0..18
//   rst_IU, flush_IU           coder reset / flush pulses
//   busy_IU                    context initialisation in progress
//   ctx_we/addr/index/mps      context store write port (also PE forwarding)
//   valid_CU, addQe_CU, Qe_CU,
//   shift_CU, A_CU             one-beat record for the code-register stage
//   rst_CU, flush_CU           forwarded coder reset / flush pulses
module mq_interval_update (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_IU,
    input  logic [15:0] Qe_value_IU,
    input  logic [5:0]  NMPS_IU,
    input  logic [5:0]  NLPS_IU,
    input  logic [3:0]  LZ0_IU,
    input  logic        MPS_update_IU,
    input  logic        MPS_coding_IU,
    input  logic [4:0]  CX_IU,
    input  logic        rst_IU,
    input  logic        flush_IU,
    output logic        busy_IU,
    output logic        ctx_we,
    output logic [4:0]  ctx_addr,
    output logic [5:0]  ctx_index,
    output logic        ctx_mps,
    output logic        valid_CU,
    output logic        addQe_CU,
    output logic [15:0] Qe_CU,
    output logic [3:0]  shift_CU,
    output logic [15:0] A_CU,
    output logic        rst_CU,
    output logic        flush_CU
);

    typedef enum logic {IDLE, INIT} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  k_reg, k_next;      // next context to initialise
    logic [15:0] a_reg, a_next;

    logic        busy_next, we_next, mps_next, valid_next, add_next;
    logic        rst_cu_next, flush_next;
    logic [4:0]  addr_next;
    logic [5:0]  index_next;
    logic [15:0] qe_next, a_cu_next;
    logic [3:0]  shift_next;

    // Datapath intermediates
    logic [16:0] diff;
    logic        diff_lt_qe;
    logic [15:0] a_pre;
    logic [31:0] a_shifted;

    function automatic logic [3:0] lzc16(input logic [15:0] v);
        logic [3:0] n;
        logic       done;
        n    = 4'd0;
        done = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + 4'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] init_index(input logic [4:0] k);
        case (k)
            5'd0:    return 6'd4;
            5'd17:   return 6'd3;
            5'd18:   return 6'd46;
            default: return 6'd0;
        endcase
    endfunction

    always_comb begin
        state_next  = state_reg;
        k_next      = k_reg;
        a_next      = a_reg;
        busy_next   = 1'b0;
        we_next     = 1'b0;
        addr_next   = 5'd0;
        index_next  = 6'd0;
        mps_next    = 1'b0;
        valid_next  = 1'b0;
        add_next    = 1'b0;
        qe_next     = 16'd0;
        shift_next  = 4'd0;
        a_cu_next   = A_CU;
        rst_cu_next = 1'b0;
        flush_next  = 1'b0;
        a_pre       = 16'd0;

        // A >= 0x8000 and Qe <= 0x5601, so the difference is never negative.
        diff       = {1'b0, a_reg} - {1'b0, Qe_value_IU};
        diff_lt_qe = diff[15:0] < Qe_value_IU;
        a_shifted  = 32'd0;

        if (rst_IU) begin
            // Coder reset wins over everything; the first init write (k=0)
            // is issued in this same cycle so busy_IU lines up with writes.
            a_next      = 16'h8000;
            rst_cu_next = 1'b1;
            state_next  = INIT;
            busy_next   = 1'b1;
            we_next     = 1'b1;
            addr_next   = 5'd0;
            index_next  = init_index(5'd0);
            k_next      = 5'd1;
        end else if (state_reg == INIT) begin
            busy_next  = 1'b1;
            we_next    = 1'b1;
            addr_next  = k_reg;
            index_next = init_index(k_reg);
            if (k_reg == 5'd18) begin
                state_next = IDLE;
                k_next     = 5'd0;
            end else begin
                k_next = k_reg + 5'd1;
            end
        end else begin
            flush_next = flush_IU;
            // busy_IU is still high while the last init write is on the
            // outputs, even though the state has already returned to IDLE.
            if (valid_IU && !busy_IU) begin
                valid_next = 1'b1;
                qe_next    = Qe_value_IU;
                addr_next  = CX_IU;
                mps_next   = MPS_update_IU;
                if (MPS_coding_IU) begin
                    index_next = NMPS_IU;
                    if (diff[15]) begin
                        a_pre      = diff[15:0];
                        add_next   = 1'b1;
                        shift_next = 4'd0;
                    end else begin
                        we_next    = 1'b1;
                        shift_next = 4'd1;
                        if (diff_lt_qe) begin
                            a_pre    = Qe_value_IU;   // conditional exchange
                            add_next = 1'b0;
                        end else begin
                            a_pre    = diff[15:0];
                            add_next = 1'b1;
                        end
                    end
                end else begin
                    index_next = NLPS_IU;
                    we_next    = 1'b1;
                    if (diff_lt_qe) begin
                        a_pre      = diff[15:0];      // conditional exchange
                        add_next   = 1'b1;
                        shift_next = lzc16(diff[15:0]);
                    end else begin
                        a_pre      = Qe_value_IU;
                        add_next   = 1'b0;
                        shift_next = LZ0_IU;
                    end
                end
                a_shifted = {16'd0, a_pre} << shift_next;
                a_next    = a_shifted[15:0];
                a_cu_next = a_shifted[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= 5'd0;
            a_reg     <= 16'h8000;
            busy_IU   <= 1'b0;
            ctx_we    <= 1'b0;
            ctx_addr  <= 5'd0;
            ctx_index <= 6'd0;
            ctx_mps   <= 1'b0;
            valid_CU  <= 1'b0;
            addQe_CU  <= 1'b0;
            Qe_CU     <= 16'd0;
            shift_CU  <= 4'd0;
            A_CU      <= 16'd0;
            rst_CU    <= 1'b0;
            flush_CU  <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            a_reg     <= a_next;
            busy_IU   <= busy_next;
            ctx_we    <= we_next;
            ctx_addr  <= addr_next;
            ctx_index <= index_next;
            ctx_mps   <= mps_next;
            valid_CU  <= valid_next;
            addQe_CU  <= add_next;
            Qe_CU     <= qe_next;
            shift_CU  <= shift_next;
            A_CU      <= a_cu_next;
            rst_CU    <= rst_cu_next;
            flush_CU  <= flush_next;
        end
    end

endmodule
